// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller: NS/EW phases with all-red clearance, EW car demand,
// latched pedestrian walk phase and a flashing-yellow fault mode.
module traffic_light_ctrl #(
  parameter int NS_GREEN_CYC = 8,
  parameter int EW_GREEN_CYC = 6,
  parameter int YELLOW_CYC   = 3,
  parameter int ALLRED_CYC   = 2,
  parameter int WALK_CYC     = 5,
  parameter int FLASH_HALF   = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ew_car,
  input  logic       ped_req,
  input  logic       flash,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    RED2  = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    RED1  = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    WALK  = 3'd6,
    FLASH = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] T_NSG    = CNT_W'(NS_GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] T_EWG    = CNT_W'(EW_GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] T_YEL    = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] T_WALK   = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] T_FLASH  = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             blink;
  logic             expired;

  assign expired = (timer == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RED2;
      timer    <= T_ALLRED;
      blink    <= 1'b1;
      ped_wait <= 1'b0;
    end else begin
      if (ped_req) ped_wait <= 1'b1;
      if (flash && state != FLASH) begin
        state <= FLASH;
        timer <= T_FLASH;
        blink <= 1'b1;
      end else if (state == FLASH) begin
        if (!flash) begin
          state <= RED2;
          timer <= T_ALLRED;
          blink <= 1'b1;
        end else if (expired) begin
          blink <= ~blink;
          timer <= T_FLASH;
        end else begin
          timer <= timer - ONE;
        end
      end else if (!expired) begin
        timer <= timer - ONE;
      end else begin
        case (state)
          RED2: begin
            // Clearing here, after the set above, lets the walk entry win over a new press.
            if (ped_wait) begin
              state    <= WALK;
              timer    <= T_WALK;
              ped_wait <= 1'b0;
            end else begin
              state <= NS_G;
              timer <= T_NSG;
            end
          end
          NS_G: begin
            // Without demand NS green rests with the timer parked at zero.
            if (ew_car || ped_wait) begin
              state <= NS_Y;
              timer <= T_YEL;
            end
          end
          NS_Y: begin
            state <= RED1;
            timer <= T_ALLRED;
          end
          RED1: begin
            state <= EW_G;
            timer <= T_EWG;
          end
          EW_G: begin
            state <= EW_Y;
            timer <= T_YEL;
          end
          EW_Y: begin
            state <= RED2;
            timer <= T_ALLRED;
          end
          WALK: begin
            state <= NS_G;
            timer <= T_NSG;
          end
          default: begin
            state <= RED2;
            timer <= T_ALLRED;
          end
        endcase
      end
    end
  end

  // Lamps decode straight from the registered state so they change with state_o.
  always_comb begin
    ns_light = L_RED;
    ew_light = L_RED;
    walk     = 1'b0;
    case (state)
      NS_G:  ns_light = L_GRN;
      NS_Y:  ns_light = L_YEL;
      EW_G:  ew_light = L_GRN;
      EW_Y:  ew_light = L_YEL;
      WALK:  walk     = 1'b1;
      FLASH: begin
        ns_light = blink ? L_YEL : L_OFF;
        ew_light = blink ? L_YEL : L_OFF;
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule
